unbyter: RTL

Byte-to-word bridge on the host-interface DI bus: the reverse of the word-to-byte serializer. It accepts a byte-wide DI stream from the host side (di0, slave) and drives a DI_DATA_WIDTH-wide DI terminal (di1, master). In write mode it packs host bytes little-endian into words. In read mode it fetches words and returns them one byte at a time, LSB first. It sits between the 8-bit host transfer engine and 16/32-bit register/RAM terminals.

---
 rtl/unbyter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/unbyter.sv
// Byte-to-word bridge on the DI bus: packs host bytes little-endian into
// DI_DATA_WIDTH words on write, and unpacks fetched words LSB-first on read.
module unbyter #(
    parameter int DI_DATA_WIDTH = 32
) (
    input  logic                     resetb,
    input  logic                     ifclk,
    input  logic                     enable,
    input  logic [31:0]              di0_len,
    input  logic                     di0_write_mode,
    input  logic                     di0_write,
    input  logic [7:0]               di0_reg_datai,
    output logic                     di0_write_rdy,
    input  logic                     di0_read_mode,
    input  logic                     di0_read_req,
    input  logic                     di0_read,
    output logic [7:0]               di0_reg_datao,
    output logic                     di0_read_rdy,
    output logic                     di1_write,
    output logic [DI_DATA_WIDTH-1:0] di1_reg_datai,
    input  logic                     di1_write_rdy,
    output logic                     di1_read_req,
    output logic                     di1_read,
    input  logic [DI_DATA_WIDTH-1:0] di1_reg_datao,
    input  logic                     di1_read_rdy
);

    localparam int unsigned BPW  = DI_DATA_WIDTH / 8;
    localparam logic [2:0]  BPW3 = 3'(BPW);

    typedef enum logic       {COLLECT, FLUSH}        wr_state_t;
    typedef enum logic [1:0] {R_IDLE, FETCH, HAVE}   rd_state_t;

    wr_state_t               wr_state, wr_state_n;
    rd_state_t               rd_state, rd_state_n;
    logic [DI_DATA_WIDTH-1:0] sr, sr_n;
    logic [2:0]              byte_pos, byte_pos_n;
    logic [2:0]              avail, avail_n;
    logic [31:0]             count, count_n;
    logic [31:0]             remaining;
    logic                    rd_rdy0, rd_rdy0_n;
    logic                    di1_write_n, di1_read_req_n, di1_read_n;
    logic                    active;

    assign active        = enable && (di0_write_mode || di0_read_mode);
    assign remaining     = di0_len - count;
    assign di0_write_rdy = enable && di0_write_mode && (wr_state == COLLECT);
    assign di0_read_rdy  = rd_rdy0 && !di0_read;
    assign di0_reg_datao = sr[7:0];
    assign di1_reg_datai = sr;

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            wr_state     <= COLLECT;
            rd_state     <= R_IDLE;
            sr           <= '0;
            byte_pos     <= '0;
            avail        <= '0;
            count        <= '0;
            rd_rdy0      <= 1'b0;
            di1_write    <= 1'b0;
            di1_read_req <= 1'b0;
            di1_read     <= 1'b0;
        end else begin
            wr_state     <= wr_state_n;
            rd_state     <= rd_state_n;
            sr           <= sr_n;
            byte_pos     <= byte_pos_n;
            avail        <= avail_n;
            count        <= count_n;
            rd_rdy0      <= rd_rdy0_n;
            di1_write    <= di1_write_n;
            di1_read_req <= di1_read_req_n;
            di1_read     <= di1_read_n;
        end
    end

    always_comb begin
        wr_state_n     = wr_state;
        rd_state_n     = rd_state;
        sr_n           = sr;
        byte_pos_n     = byte_pos;
        avail_n        = avail;
        count_n        = count;
        rd_rdy0_n      = rd_rdy0;
        di1_write_n    = di1_write;
        di1_read_req_n = di1_read_req;
        di1_read_n     = di1_read;

        if (!active) begin
            // partial words are dropped here, never flushed
            wr_state_n     = COLLECT;
            rd_state_n     = R_IDLE;
            sr_n           = '0;
            byte_pos_n     = '0;
            avail_n        = '0;
            count_n        = '0;
            rd_rdy0_n      = 1'b0;
            di1_write_n    = 1'b0;
            di1_read_req_n = 1'b0;
            di1_read_n     = 1'b0;
        end else if (di0_write_mode) begin
            case (wr_state)
                COLLECT: begin
                    if (di0_write) begin
                        for (int unsigned i = 0; i < BPW; i++) begin
                            if (byte_pos == 3'(i))
                                sr_n[8*i +: 8] = di0_reg_datai;
                        end
                        byte_pos_n = byte_pos + 3'd1;
                        count_n    = count + 32'd1;
                        if ((byte_pos + 3'd1 == BPW3) ||
                            (di0_len != '0 && count + 32'd1 == di0_len))
                            wr_state_n = FLUSH;
                    end
                end
                FLUSH: begin
                    if (di1_write) begin
                        di1_write_n = 1'b0;
                        sr_n        = '0;
                        byte_pos_n  = '0;
                        wr_state_n  = COLLECT;
                    end else if (di1_write_rdy) begin
                        di1_write_n = 1'b1;
                    end
                end
                default: wr_state_n = COLLECT;
            endcase
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (di0_read_req) begin
                        if (avail != '0) begin
                            rd_rdy0_n  = 1'b1;
                            rd_state_n = HAVE;
                        end else begin
                            di1_read_req_n = 1'b1;
                            rd_state_n     = FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (di1_read) begin
                        sr_n           = di1_reg_datao;
                        di1_read_n     = 1'b0;
                        di1_read_req_n = 1'b0;
                        rd_rdy0_n      = 1'b1;
                        rd_state_n     = HAVE;
                        // the final word of a bounded transfer only yields the bytes still owed
                        if (di0_len != '0 && count < di0_len && remaining < 32'(BPW))
                            avail_n = remaining[2:0];
                        else
                            avail_n = BPW3;
                    end else if (di1_read_rdy) begin
                        di1_read_n = 1'b1;
                    end
                end
                HAVE: begin
                    if (di0_read && rd_rdy0) begin
                        sr_n       = sr >> 8;
                        avail_n    = avail - 3'd1;
                        count_n    = count + 32'd1;
                        rd_rdy0_n  = 1'b0;
                        rd_state_n = R_IDLE;
                    end
                end
                default: rd_state_n = R_IDLE;
            endcase
        end
    end

endmodule
